// File: rtl/aq_ifu_ibuf_ctrl_pkg.sv
// Shared sizing constants and helpers for the IFU instruction-buffer sequencer.
// Imported by aq_ifu_ibuf_ctrl and aq_ifu_ibuf_ptr.
package aq_ifu_ibuf_ctrl_pkg;

    localparam int IBUF_ENTRY_NUM  = 8;
    localparam int IBUF_CNT_W      = 4;
    localparam int IBUF_CREATE_MAX = 3;
    localparam int IBUF_RETIRE_MAX = 2;
    localparam int IBUF_WARMUP_CYC = 2;

    // Retire count clamped to what is already resident at cycle start.
    function automatic logic [1:0] ibuf_ret_num(input logic [1:0] req,
                                                input logic       cnt_is0,
                                                input logic       cnt_is1);
        if (req == 2'd0 || cnt_is0)
            return 2'd0;
        else if (req == 2'd1 || cnt_is1)
            return 2'd1;
        else
            return 2'(IBUF_RETIRE_MAX);
    endfunction

endpackage

// File: rtl/aq_ifu_ibuf_ptr.sv
// One-hot rotating pointer: advances by 0..3 per cycle, returns to bit0 on clear.
// Also exposes the next two slots for multi-entry create/retire.
module aq_ifu_ibuf_ptr
    import aq_ifu_ibuf_ctrl_pkg::*;
#(
    parameter int ENTRY_NUM = IBUF_ENTRY_NUM
) (
    input  logic                 ibuf_cpuclk,
    input  logic                 cpurst_b,
    input  logic [1:0]           step,
    input  logic                 clear,
    output logic [ENTRY_NUM-1:0] ptr,
    output logic [ENTRY_NUM-1:0] ptr_p1,
    output logic [ENTRY_NUM-1:0] ptr_p2
);

    localparam logic [ENTRY_NUM-1:0] PTR_RST = ENTRY_NUM'(1);

    function automatic logic [ENTRY_NUM-1:0] rotl(input logic [ENTRY_NUM-1:0] v,
                                                  input logic [1:0]           n);
        logic [2*ENTRY_NUM-1:0] d;
        d = {v, v} << n;
        return d[2*ENTRY_NUM-1:ENTRY_NUM];
    endfunction

    always_ff @(posedge ibuf_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b)
            ptr <= PTR_RST;
        else if (clear)
            ptr <= PTR_RST;
        else
            ptr <= rotl(ptr, step);
    end

    assign ptr_p1 = rotl(ptr, 2'd1);
    assign ptr_p2 = rotl(ptr, 2'd2);

endmodule

// File: rtl/aq_ifu_ibuf_ctrl.sv
// IFU instruction-buffer sequencer: pointers, occupancy, create/retire/flush strobes.
// Optional post-reset warm-up window is enabled by defining AQ_IFU_IBUF_WARMUP_EN.
module aq_ifu_ibuf_ctrl
    import aq_ifu_ibuf_ctrl_pkg::*;
#(
    parameter int ENTRY_NUM  = IBUF_ENTRY_NUM,
    parameter int CNT_W      = IBUF_CNT_W,
    parameter int WARMUP_CYC = IBUF_WARMUP_CYC
) (
    input  logic                 ibuf_cpuclk,
    input  logic                 cpurst_b,
    input  logic                 ifu_ibuf_create_vld,
    input  logic [1:0]           ifu_ibuf_create_num,
    input  logic [1:0]           idu_ibuf_retire_num,
    input  logic                 rtu_ifu_flush,
    output logic                 ibuf_ifu_stall,
    output logic [ENTRY_NUM-1:0] ibuf_entry_create0_en,
    output logic [ENTRY_NUM-1:0] ibuf_entry_create0_data_en,
    output logic [ENTRY_NUM-1:0] ibuf_entry_create1_en,
    output logic [ENTRY_NUM-1:0] ibuf_entry_create1_data_en,
    output logic [ENTRY_NUM-1:0] ibuf_entry_create2_en,
    output logic [ENTRY_NUM-1:0] ibuf_entry_create2_data_en,
    output logic [ENTRY_NUM-1:0] ibuf_entry_retire0_en,
    output logic [ENTRY_NUM-1:0] ibuf_entry_retire1_en,
    output logic                 ibuf_flush_en,
    output logic [ENTRY_NUM-1:0] ibuf_retire_ptr,
    output logic [CNT_W-1:0]     ibuf_cnt,
    output logic                 ibuf_empty,
    output logic                 ibuf_full,
    output logic                 vec_ibuf_warm_up
);

    logic                 warming;
    logic                 space_ok;
    logic                 create_ok;
    logic [1:0]           create_step;
    logic [1:0]           ret_num;
    logic                 retire_act;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     free;
    logic [ENTRY_NUM-1:0] create_ptr;
    logic [ENTRY_NUM-1:0] create_ptr_p1;
    logic [ENTRY_NUM-1:0] create_ptr_p2;
    logic [ENTRY_NUM-1:0] retire_ptr;
    logic [ENTRY_NUM-1:0] retire_ptr_p1;
    logic [ENTRY_NUM-1:0] retire_ptr_p2_unused;

`ifdef AQ_IFU_IBUF_WARMUP_EN
    localparam int WARM_W = $clog2(WARMUP_CYC + 1);
    logic [WARM_W-1:0] warm_cnt;

    // Loaded only by reset, so a flush never reopens the window.
    always_ff @(posedge ibuf_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b)
            warm_cnt <= WARM_W'(WARMUP_CYC);
        else if (warm_cnt != '0)
            warm_cnt <= warm_cnt - 1'b1;
    end

    assign warming = (warm_cnt != '0);
`else
    localparam int WARMUP_CYC_unused = WARMUP_CYC;
    assign warming = 1'b0;
`endif

    assign vec_ibuf_warm_up = warming;

    // Space is judged on cycle-start occupancy: same-cycle retires never free a slot.
    assign free        = CNT_W'(ENTRY_NUM) - cnt_q;
    assign space_ok    = (CNT_W'(ifu_ibuf_create_num) <= free);
    assign create_ok   = ifu_ibuf_create_vld & space_ok & ~warming;
    assign create_step = create_ok ? ifu_ibuf_create_num : 2'd0;
    assign ibuf_ifu_stall = ifu_ibuf_create_vld & (ifu_ibuf_create_num != 2'd0) & ~create_ok;

    assign ret_num    = ibuf_ret_num(idu_ibuf_retire_num, cnt_q == '0, cnt_q == CNT_W'(1));
    assign retire_act = ~rtu_ifu_flush;

    // data_en ignores flush to keep flush off the entry data-enable path.
    assign ibuf_entry_create0_data_en = (create_ok && create_step >= 2'd1) ? create_ptr    : '0;
    assign ibuf_entry_create1_data_en = (create_ok && create_step >= 2'd2) ? create_ptr_p1 : '0;
    assign ibuf_entry_create2_data_en = (create_ok && create_step == 2'd3) ? create_ptr_p2 : '0;

    assign ibuf_entry_create0_en = ibuf_entry_create0_data_en & {ENTRY_NUM{~rtu_ifu_flush}};
    assign ibuf_entry_create1_en = ibuf_entry_create1_data_en & {ENTRY_NUM{~rtu_ifu_flush}};
    assign ibuf_entry_create2_en = ibuf_entry_create2_data_en & {ENTRY_NUM{~rtu_ifu_flush}};

    assign ibuf_entry_retire0_en = (retire_act && ret_num != 2'd0) ? retire_ptr    : '0;
    assign ibuf_entry_retire1_en = (retire_act && ret_num == 2'd2) ? retire_ptr_p1 : '0;

    assign ibuf_flush_en   = rtu_ifu_flush;
    assign ibuf_retire_ptr = retire_ptr;
    assign ibuf_cnt        = cnt_q;
    assign ibuf_empty      = (cnt_q == '0);
    assign ibuf_full       = (cnt_q == CNT_W'(ENTRY_NUM));

    always_ff @(posedge ibuf_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b)
            cnt_q <= '0;
        else if (rtu_ifu_flush)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + CNT_W'(create_step) - CNT_W'(ret_num);
    end

    aq_ifu_ibuf_ptr #(.ENTRY_NUM(ENTRY_NUM)) u_create_ptr (
        .ibuf_cpuclk (ibuf_cpuclk),
        .cpurst_b    (cpurst_b),
        .step        (create_step),
        .clear       (rtu_ifu_flush),
        .ptr         (create_ptr),
        .ptr_p1      (create_ptr_p1),
        .ptr_p2      (create_ptr_p2)
    );

    aq_ifu_ibuf_ptr #(.ENTRY_NUM(ENTRY_NUM)) u_retire_ptr (
        .ibuf_cpuclk (ibuf_cpuclk),
        .cpurst_b    (cpurst_b),
        .step        (ret_num),
        .clear       (rtu_ifu_flush),
        .ptr         (retire_ptr),
        .ptr_p1      (retire_ptr_p1),
        .ptr_p2      (retire_ptr_p2_unused)
    );

endmodule
